// File: rtl/sdram_dma_ctrl.sv
// rtl/sdram_dma_ctrl.sv - command-driven DMA between the 128-bit tile buffer and the SDRAM wrapper
// Loads move wrapper read beats into the buffer; stores stream buffer words out through the wrapper.
module sdram_dma_ctrl #(
  parameter int BUF_AW  = 10,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [31:0]       cmd_sdram_addr,
  input  logic [BUF_AW-1:0] cmd_buf_addr,
  input  logic [10:0]       cmd_beats,
  output logic              busy,
  output logic              sts_done,
  output logic              sts_err,
  output logic              buf_wr_en,
  output logic [BUF_AW-1:0] buf_wr_addr,
  output logic [127:0]      buf_wr_data,
  output logic              buf_rd_en,
  output logic [BUF_AW-1:0] buf_rd_addr,
  input  logic [127:0]      buf_rd_data,
  output logic [31:0]       sd_rw_addr,
  output logic [10:0]       sd_rw_cnt,
  input  logic              sd_rw_done,
  output logic              sd_read_start,
  input  logic [127:0]      sd_read_data,
  input  logic              sd_read_valid,
  output logic              sd_write_start,
  output logic [127:0]      sd_write_data,
  input  logic              sd_write_nxt
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_START, S_RD_DATA, S_WR_PREF, S_WR_START, S_WR_DATA, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BUF_AW-1:0] base_q, base_d;
  logic [10:0]       beats_q, beats_d;
  logic [31:0]       rw_addr_q, rw_addr_d;
  logic [10:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic              wr_en_q, wr_en_d;
  logic [BUF_AW-1:0] wr_addr_q, wr_addr_d;
  logic [127:0]      wr_data_q, wr_data_d;

  logic [10:0] cnt_nx;
  logic        more_to_send;
  logic        rd_event, wr_event, wdog_expired;

  assign cnt_nx       = cnt_q + 11'd1;
  assign more_to_send = ({1'b0, cnt_q} + 12'd1) < {1'b0, beats_q};
  assign rd_event     = sd_read_valid || sd_rw_done;
  assign wr_event     = sd_write_nxt || sd_rw_done;
  assign wdog_expired = (wdog_q == WDW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    beats_d   = beats_q;
    rw_addr_d = rw_addr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wdog_d    = wdog_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          base_d    = cmd_buf_addr;
          beats_d   = cmd_beats;
          rw_addr_d = cmd_sdram_addr & ~32'hF;
          cnt_d     = '0;
          err_d     = 1'b0;
          if (cmd_beats == 11'd0) state_d = S_DONE;
          else if (cmd_write)     state_d = S_WR_PREF;
          else                    state_d = S_RD_START;
        end
      end
      S_RD_START: begin
        state_d = S_RD_DATA;
        wdog_d  = '0;
      end
      S_RD_DATA: begin
        wdog_d = rd_event ? '0 : wdog_q + WDW'(1);
        if (sd_read_valid) begin
          if (cnt_q < beats_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q + BUF_AW'(cnt_q);
            wr_data_d = sd_read_data;
            cnt_d     = cnt_nx;
          end else begin
            err_d = 1'b1;
          end
        end
        // A final beat arriving with rw_done is already folded into cnt_d here.
        if (sd_rw_done) begin
          state_d = S_DONE;
          if (cnt_d != beats_q) err_d = 1'b1;
        end else if (!rd_event && wdog_expired) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_WR_PREF: state_d = S_WR_START;
      S_WR_START: begin
        state_d = S_WR_DATA;
        wdog_d  = '0;
      end
      S_WR_DATA: begin
        wdog_d = wr_event ? '0 : wdog_q + WDW'(1);
        if (sd_write_nxt) begin
          if (cnt_q < beats_q) cnt_d = cnt_nx;
          else                 err_d = 1'b1;
        end
        if (sd_rw_done) begin
          state_d = S_DONE;
          if (cnt_d != beats_q) err_d = 1'b1;
        end else if (!wr_event && wdog_expired) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        rw_addr_d = '0;
        beats_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      beats_q   <= '0;
      rw_addr_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      beats_q   <= beats_d;
      rw_addr_q <= rw_addr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wdog_q    <= wdog_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Store prefetch runs one word ahead so back-to-back write_nxt always sees fresh data.
  assign buf_rd_en   = (state_q == S_WR_PREF) ||
                       ((state_q == S_WR_DATA) && sd_write_nxt && more_to_send);
  assign buf_rd_addr = !buf_rd_en ? '0 :
                       (state_q == S_WR_PREF) ? base_q : base_q + BUF_AW'(cnt_nx);

  assign cmd_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign sts_done       = (state_q == S_DONE);
  assign sts_err        = (state_q == S_DONE) && err_q;
  assign sd_read_start  = (state_q == S_RD_START);
  assign sd_write_start = (state_q == S_WR_START);
  assign sd_rw_addr     = rw_addr_q;
  assign sd_rw_cnt      = beats_q;
  assign sd_write_data  = ((state_q == S_WR_START) || (state_q == S_WR_DATA)) ? buf_rd_data : '0;
  assign buf_wr_en      = wr_en_q;
  assign buf_wr_addr    = wr_addr_q;
  assign buf_wr_data    = wr_data_q;

endmodule

// File: tb/tb_sdram_dma_ctrl.sv
// tb/tb_sdram_dma_ctrl.sv - scoreboard bench for sdram_dma_ctrl
module tb_sdram_dma_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [31:0]  cmd_sdram_addr;
  logic [9:0]   cmd_buf_addr;
  logic [10:0]  cmd_beats;
  logic         busy, sts_done, sts_err;
  logic         buf_wr_en, buf_rd_en;
  logic [9:0]   buf_wr_addr, buf_rd_addr;
  logic [127:0] buf_wr_data;
  logic [127:0] buf_rd_data = '0;
  logic [31:0]  sd_rw_addr;
  logic [10:0]  sd_rw_cnt;
  logic         sd_rw_done, sd_read_start, sd_read_valid, sd_write_start, sd_write_nxt;
  logic [127:0] sd_read_data, sd_write_data;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_starts = 0;
  int wr_starts = 0;

  logic [9:0]   exp_wa[$];
  logic [127:0] exp_wd[$];
  logic [127:0] exp_sdw[$];
  logic         exp_err[$];

  logic [127:0] bmem [1024];

  sdram_dma_ctrl #(.BUF_AW(10), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sdram_addr(cmd_sdram_addr), .cmd_buf_addr(cmd_buf_addr), .cmd_beats(cmd_beats),
    .busy(busy), .sts_done(sts_done), .sts_err(sts_err),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .sd_rw_addr(sd_rw_addr), .sd_rw_cnt(sd_rw_cnt), .sd_rw_done(sd_rw_done),
    .sd_read_start(sd_read_start), .sd_read_data(sd_read_data), .sd_read_valid(sd_read_valid),
    .sd_write_start(sd_write_start), .sd_write_data(sd_write_data), .sd_write_nxt(sd_write_nxt)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] bword(input int i);
    return {4{32'hB000_0000 | 32'(i)}};
  endfunction

  function automatic logic [127:0] sword(input int k);
    return {4{32'h5D00_0000 | 32'(k)}};
  endfunction

  always @(posedge clk) if (buf_rd_en) buf_rd_data <= bmem[buf_rd_addr];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic logic outs_nonzero();
    return |{buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_en, buf_rd_addr, sd_rw_addr, sd_rw_cnt,
             sd_read_start, sd_write_start, sd_write_data, sts_done, sts_err, busy};
  endfunction

  // Monitor: pops expectations whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (!reset) begin
      if (sd_read_start) rd_starts++;
      if (sd_write_start) wr_starts++;
      chk("ready_vs_busy", cmd_ready, !busy);
      if (buf_wr_en) begin
        if (exp_wa.size() == 0) miss("buf_wr_unexpected");
        else begin
          chk("buf_wr_addr", buf_wr_addr, exp_wa.pop_front());
          chk("buf_wr_data", buf_wr_data, exp_wd.pop_front());
        end
      end
      if (sd_write_nxt) begin
        if (exp_sdw.size() == 0) miss("sd_write_unexpected");
        else chk("sd_write_data", sd_write_data, exp_sdw.pop_front());
      end
      if (sts_done) begin
        if (exp_err.size() == 0) miss("sts_done_unexpected");
        else chk("sts_err", sts_err, exp_err.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) miss("wait_idle_timeout");
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [9:0] b, input logic [10:0] n);
    wait_idle();
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_sdram_addr = a;
    cmd_buf_addr = b;
    cmd_beats = n;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rd_beat(input int k, input logic done, input logic [9:0] wa);
    sd_read_valid = 1'b1;
    sd_read_data  = sword(k);
    sd_rw_done    = done;
    exp_wa.push_back(wa);
    exp_wd.push_back(sword(k));
    tick();
    sd_read_valid = 1'b0;
    sd_rw_done    = 1'b0;
    tick();
  endtask

  task automatic rw_done_pulse();
    sd_rw_done = 1'b1;
    tick();
    sd_rw_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int rs0, ws0;
    for (int i = 0; i < 1024; i++) bmem[i] = bword(i);
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sdram_addr = '0;
    cmd_buf_addr = '0; cmd_beats = '0; sd_rw_done = 1'b0; sd_read_valid = 1'b0;
    sd_read_data = '0; sd_write_nxt = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_outputs_zero", outs_nonzero(), 1'b0);
    chk("reset_cmd_ready", cmd_ready, 1'b1);

    // Load 4 beats with gaps, unaligned address
    exp_err.push_back(1'b0);
    issue(1'b0, 32'h1000_0007, 10'd0, 11'd4);
    chk("load_rw_addr", sd_rw_addr, 32'h1000_0000);
    chk("load_rw_cnt", sd_rw_cnt, 11'd4);
    chk("load_read_start", sd_read_start, 1'b1);
    tick();
    chk("load_read_start_pulse", sd_read_start, 1'b0);
    for (int k = 0; k < 4; k++) rd_beat(k, 1'b0, 10'(k));
    rw_done_pulse();
    wait_idle();
    chk("load_rd_starts", rd_starts, 1);

    // Store across the buffer wrap with back-to-back write_nxt
    exp_err.push_back(1'b0);
    exp_sdw.push_back(bword(1022));
    exp_sdw.push_back(bword(1023));
    exp_sdw.push_back(bword(0));
    exp_sdw.push_back(bword(1));
    issue(1'b1, 32'h2000_0000, 10'd1022, 11'd4);
    tick();
    chk("store_write_start", sd_write_start, 1'b1);
    tick();
    sd_write_nxt = 1'b1;
    repeat (4) tick();
    sd_write_nxt = 1'b0;
    rw_done_pulse();
    wait_idle();
    chk("store_wr_starts", wr_starts, 1);

    // Load 3 beats, rw_done coincident with the last beat
    exp_err.push_back(1'b0);
    issue(1'b0, 32'h3000_0040, 10'd10, 11'd3);
    tick();
    rd_beat(0, 1'b0, 10'd10);
    rd_beat(1, 1'b0, 10'd11);
    rd_beat(2, 1'b1, 10'd12);
    wait_idle();

    // Load 3 beats, wrapper finishes after only 2
    exp_err.push_back(1'b1);
    issue(1'b0, 32'h3000_0080, 10'd20, 11'd3);
    tick();
    rd_beat(5, 1'b0, 10'd20);
    rd_beat(6, 1'b0, 10'd21);
    rw_done_pulse();
    wait_idle();

    // Zero beats
    rs0 = rd_starts; ws0 = wr_starts;
    exp_err.push_back(1'b0);
    issue(1'b0, 32'h4000_0000, 10'd0, 11'd0);
    chk("zero_done_fast", sts_done, 1'b1);
    chk("zero_busy", busy, 1'b1);
    tick();
    chk("zero_ready_again", cmd_ready, 1'b1);
    chk("zero_no_starts", (rd_starts - rs0) + (wr_starts - ws0), 0);

    // Store with a silent wrapper: watchdog abort after 16 idle cycles
    exp_err.push_back(1'b1);
    issue(1'b1, 32'h5000_0000, 10'd5, 11'd2);
    tick();
    tick();
    n = 0;
    while (!sts_done && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 16);
    exp_err.push_back(1'b0);
    issue(1'b0, 32'h5000_0100, 10'd0, 11'd0);
    chk("post_timeout_accept", sts_done, 1'b1);
    wait_idle();

    // Reset in the middle of an 8-beat load
    issue(1'b0, 32'h6000_0000, 10'd100, 11'd8);
    tick();
    rd_beat(0, 1'b0, 10'd100);
    rd_beat(1, 1'b0, 10'd101);
    reset = 1'b1;
    tick();
    chk("midreset_outputs_zero", outs_nonzero(), 1'b0);
    chk("midreset_cmd_ready", cmd_ready, 1'b1);
    reset = 1'b0;
    repeat (4) tick();

    chk("left_buf_writes", exp_wa.size(), 0);
    chk("left_sd_writes", exp_sdw.size(), 0);
    chk("left_status", exp_err.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_dma_ctrl.md
Name: sdram_dma_ctrl

Overview:
- Command-driven transfer engine between the NPU's on-chip 128-bit tile buffer and the SDRAM wrapper conduit (rw/read/write interfaces) exported by the HPS SoC system.
- Per command, moves N 128-bit beats SDRAM→buffer (load) or buffer→SDRAM (store).
- Generates the wrapper's start pulses and address/count, sequences data beats, and reports completion and error status to the NPU controller.

Parameters:
- BUF_AW, 10, tile-buffer word address width; buffer addresses wrap modulo 2^BUF_AW.
- TIMEOUT, 65535, max idle cycles between SDRAM events in a data phase before abort.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = store (buffer→SDRAM), 0 = load.
- cmd_sdram_addr  in  32  byte address; bits [3:0] forced to 0.
- cmd_buf_addr  in  BUF_AW  first buffer word.
- cmd_beats  in  11  beat count, 0..2047.
- busy  out  1  high from accept through DONE.
- sts_done  out  1  one-cycle completion pulse.
- sts_err  out  1  valid only with sts_done.
- buf_wr_en  out  1  buffer write strobe.
- buf_wr_addr  out  BUF_AW  buffer write address.
- buf_wr_data  out  128  buffer write data.
- buf_rd_en  out  1  buffer read strobe.
- buf_rd_addr  out  BUF_AW  buffer read address.
- buf_rd_data  in  128  registered read data, valid the cycle after buf_rd_en; holds while buf_rd_en is low.
- sd_rw_addr  out  32  to wrapper rw_addr.
- sd_rw_cnt  out  11  to wrapper rw_cnt.
- sd_rw_done  in  1  wrapper transfer-complete pulse.
- sd_read_start  out  1  one-cycle pulse.
- sd_read_data  in  128  wrapper read data.
- sd_read_valid  in  1  wrapper read-beat strobe.
- sd_write_start  out  1  one-cycle pulse.
- sd_write_data  out  128  wrapper write data.
- sd_write_nxt  in  1  wrapper consumed sd_write_data this cycle.

Behaviour:
- States: IDLE, RD_START, RD_DATA, WR_PREF, WR_START, WR_DATA, DONE.
- Reset:
  - All outputs 0; state IDLE; counters 0.
  - Reset mid-transfer aborts with no sts_done. It must be asserted together with the wrapper's reset.
- Accept:
  - A command is accepted on cmd_valid && cmd_ready. All fields are latched.
  - sd_rw_addr = {addr[31:4], 4'b0} and sd_rw_cnt = beats are driven from the cycle after accept and held until DONE.
- Zero beats: go straight to DONE (sts_err=0); no SDRAM or buffer activity.
- Load:
  - RD_START asserts sd_read_start for exactly 1 cycle, then moves to RD_DATA.
  - Each sd_read_valid with rcv < beats: on the next cycle buf_wr_en=1, buf_wr_addr = base+rcv (wrapping), buf_wr_data = sd_read_data; then rcv++.
  - A sd_read_valid with rcv ≥ beats is dropped and sets the error flag.
  - On sd_rw_done (including the same cycle as the final sd_read_valid, which is counted first): go to DONE. err |= (rcv != beats).
- Store:
  - WR_PREF: buf_rd_en=1 at base.
  - WR_START: sd_write_data = buf_rd_data (combinational pass-through); sd_write_start=1 for 1 cycle.
  - WR_DATA: on each sd_write_nxt, sent++. If sent+1 < beats, buf_rd_en=1 at base+sent+1 that cycle, so the next beat appears on sd_write_data the following cycle.
  - Back-to-back sd_write_nxt must be supported.
  - On sd_rw_done: go to DONE. err |= (sent != beats).
- Watchdog:
  - Counter clears on entry to RD_DATA/WR_DATA and on any sd_read_valid, sd_write_nxt or sd_rw_done.
  - On reaching TIMEOUT: go to DONE with err=1.
- DONE: sts_done=1 and sts_err for 1 cycle; busy drops; return to IDLE. Earliest next accept is the following cycle.
- Buffer address arithmetic is modulo 2^BUF_AW.
- Beat counters are 11-bit, with no overflow since they are capped at beats.

Test Plan:
- Load, addr=0x1000_0007, buf=0, beats=4, wrapper returns 4 beats with gaps → sd_rw_addr=0x1000_0000, one read_start pulse; buf words 0..3 written in order; sts_done with err=0.
- Store, buf=1022, beats=4, write_nxt asserted 4 consecutive cycles → sd_write_data sequence = buffer words 1022, 1023, 0, 1; err=0.
- Load, beats=3, rw_done on the same cycle as the 3rd read_valid → all 3 written; done err=0. Repeat with rw_done after only 2 beats → err=1.
- beats=0 → sts_done within 2 cycles of accept, no start pulses, err=0; cmd_ready low only while busy.
- Store with the wrapper silent after write_start, TIMEOUT=16 → sts_done err=1 at 16 idle cycles; then a new command is accepted.
- Reset asserted mid-load after 2 of 8 beats → next cycle all outputs 0, cmd_ready=1, no sts_done.
